// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV32 decode stage. Accepts fetched instructions, reads operands
//             from register_file, decodes fields and the immediate into an
//             output pipeline register, and stalls RAW hazards against a
//             per-register busy scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int INSTR_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  output logic [ADDRESS_WIDTH-1:0] read1_id,
  output logic [ADDRESS_WIDTH-1:0] read2_id,
  input  logic [DATA_WIDTH-1:0]    read1_data,
  input  logic [DATA_WIDTH-1:0]    read2_data,
  input  logic                     retire_en,
  input  logic [ADDRESS_WIDTH-1:0] retire_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [ADDRESS_WIDTH-1:0] out_rd,
  output logic                     out_rd_en,
  output logic [DATA_WIDTH-1:0]    out_rs1_data,
  output logic [DATA_WIDTH-1:0]    out_rs2_data,
  output logic [DATA_WIDTH-1:0]    out_imm,
  output logic                     out_illegal
);

  localparam int         c_num_regs   = 1 << ADDRESS_WIDTH;
  localparam logic [6:0] c_op_lui     = 7'b0110111;
  localparam logic [6:0] c_op_auipc   = 7'b0010111;
  localparam logic [6:0] c_op_jal     = 7'b1101111;
  localparam logic [6:0] c_op_jalr    = 7'b1100111;
  localparam logic [6:0] c_op_branch  = 7'b1100011;
  localparam logic [6:0] c_op_load    = 7'b0000011;
  localparam logic [6:0] c_op_store   = 7'b0100011;
  localparam logic [6:0] c_op_opimm   = 7'b0010011;
  localparam logic [6:0] c_op_op      = 7'b0110011;

  // Pipeline output register and scoreboard state
  logic                     out_valid_q,    out_valid_d;
  logic [DATA_WIDTH-1:0]    out_pc_q,       out_pc_d;
  logic [INSTR_WIDTH-1:0]   out_instr_q,    out_instr_d;
  logic                     out_rd_en_q,    out_rd_en_d;
  logic [DATA_WIDTH-1:0]    out_rs1_data_q, out_rs1_data_d;
  logic [DATA_WIDTH-1:0]    out_rs2_data_q, out_rs2_data_d;
  logic [DATA_WIDTH-1:0]    out_imm_q,      out_imm_d;
  logic                     out_illegal_q,  out_illegal_d;
  logic [c_num_regs-1:0]    sb_q,           sb_d;

  // Decode results for the presented instruction
  logic                     uses_rs1, uses_rs2, writes_rd, illegal;
  logic [DATA_WIDTH-1:0]    imm_dec;
  logic [DATA_WIDTH-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [ADDRESS_WIDTH-1:0] rd_dec;
  logic                     rd_en_dec;
  logic                     busy1, busy2, hazard, accept;

  assign read1_id = in_instr[19:15];
  assign read2_id = in_instr[24:20];
  assign rd_dec   = in_instr[11:7];

  // Immediate formats; bit 31 is always the sign
  assign imm_i = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = DATA_WIDTH'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = {{(DATA_WIDTH-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Opcode classification: operand usage, rd write and immediate selection
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    imm_dec   = '0;
    case (in_instr[6:0])
      c_op_lui, c_op_auipc: begin writes_rd = 1'b1; imm_dec = imm_u; end
      c_op_jal:             begin writes_rd = 1'b1; imm_dec = imm_j; end
      c_op_jalr, c_op_load, c_op_opimm: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1; imm_dec = imm_i;
      end
      c_op_branch: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_dec = imm_b; end
      c_op_store:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_dec = imm_s; end
      c_op_op: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign rd_en_dec = writes_rd && (rd_dec != '0);

  // A retire in this very cycle is not a hazard: register_file bypasses its write
  assign busy1  = (read1_id != '0) && sb_q[read1_id] && !(retire_en && retire_id == read1_id);
  assign busy2  = (read2_id != '0) && sb_q[read2_id] && !(retire_en && retire_id == read2_id);
  assign hazard = (uses_rs1 && busy1) || (uses_rs2 && busy2);

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: retire clear, then flush clear, then issue set wins
  always_comb begin
    sb_d = sb_q;
    if (retire_en)
      sb_d[retire_id] = 1'b0;
    if (flush && out_valid_q && out_rd_en_q)
      sb_d[out_instr_q[11:7]] = 1'b0;
    if (accept && rd_en_dec)
      sb_d[rd_dec] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Output register next state: load on accept, drain on handshake or flush
  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_instr_d    = out_instr_q;
    out_rd_en_d    = out_rd_en_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_imm_d      = out_imm_q;
    out_illegal_d  = out_illegal_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_pc_d       = in_pc;
      out_instr_d    = in_instr;
      out_rd_en_d    = rd_en_dec;
      out_rs1_data_d = read1_data;
      out_rs2_data_d = read2_data;
      out_imm_d      = imm_dec;
      out_illegal_d  = illegal;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_instr_q    <= '0;
      out_rd_en_q    <= 1'b0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_imm_q      <= '0;
      out_illegal_q  <= 1'b0;
      sb_q           <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_instr_q    <= out_instr_d;
      out_rd_en_q    <= out_rd_en_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_imm_q      <= out_imm_d;
      out_illegal_q  <= out_illegal_d;
      sb_q           <= sb_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_opcode   = out_instr_q[6:0];
  assign out_funct3   = out_instr_q[14:12];
  assign out_funct7   = out_instr_q[31:25];
  assign out_rd       = out_instr_q[11:7];
  assign out_rd_en    = out_rd_en_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_imm      = out_imm_q;
  assign out_illegal  = out_illegal_q;

endmodule
`default_nettype wire
